rx_bitalign_train_ctrl: RTL and testbench

Training controller for one receive lane of the RX IOD bit-alignment path. It sweeps the input-delay tap from 0 to TAP_MAX and compares the deserialized 8-bit word against a fixed training pattern, with optional bit-order reversal. It finds the longest contiguous passing tap window, then reloads the delay and steps it to the window centre. It sits between the lane's 8-bit deserializer output and the IOD delay-control pins, and reports lock or failure to the link-level sequencer.

---
 rtl/rx_bitalign_train_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rx_bitalign_train_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bitalign_train_ctrl.sv
// RX IOD bit-alignment training controller: sweeps the delay tap, finds the
// longest contiguous passing window against a training word, then seeks its centre.
module rx_bitalign_train_ctrl #(
   parameter int unsigned TAP_MAX       = 127,
   parameter int unsigned SETTLE_CYC    = 8,
   parameter int unsigned SAMPLE_CNT    = 16,
   parameter logic [7:0]  TRAIN_PATTERN = 8'hB4,
   parameter int unsigned MIN_EYE       = 4
) (
   input  logic       SCLK,
   input  logic       RESET,
   input  logic       TRAIN_START,
   input  logic       REV_EN,
   input  logic [7:0] RX_DATA,
   output logic       DLY_LOAD,
   output logic       DLY_MOVE,
   output logic [6:0] TAP_CUR,
   output logic [6:0] EYE_START,
   output logic [6:0] EYE_END,
   output logic       BUSY,
   output logic       TRAIN_DONE,
   output logic       TRAIN_ERR
);

   localparam int unsigned CNT_MAX = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, RELOAD,
      SEEK_SETTLE, SEEK_MOVE, DONE, ERR
   } state_t;

   state_t        state_q, state_n;
   logic          rev_q, rev_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          pass_q, pass_n;
   logic          in_run_q, in_run_n;
   logic [6:0]    run_start_q, run_start_n;
   logic [6:0]    best_start_q, best_start_n;
   logic [6:0]    best_end_q, best_end_n;
   logic [7:0]    best_width_q, best_width_n;
   logic [6:0]    target_q, target_n;
   logic [6:0]    tap_q, tap_n;
   logic          dly_load_q, dly_load_n;
   logic          dly_move_q, dly_move_n;
   logic          busy_q, busy_n;
   logic          done_q, done_n;
   logic          err_q, err_n;

   logic [7:0]    rx_word;
   logic [6:0]    run_s;
   logic [7:0]    width;
   logic [7:0]    mid_sum;

   always_comb begin
      rx_word = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         rx_word[i] = rev_q ? RX_DATA[7-i] : RX_DATA[i];
      end
   end

   always_comb begin
      state_n      = state_q;
      rev_n        = rev_q;
      cnt_n        = cnt_q;
      pass_n       = pass_q;
      in_run_n     = in_run_q;
      run_start_n  = run_start_q;
      best_start_n = best_start_q;
      best_end_n   = best_end_q;
      best_width_n = best_width_q;
      target_n     = target_q;
      tap_n        = tap_q;
      run_s        = in_run_q ? run_start_q : tap_q;
      width        = {1'b0, tap_q} - {1'b0, run_s} + 8'd1;
      mid_sum      = {1'b0, best_start_q} + {1'b0, best_end_q};

      case (state_q)
         IDLE, DONE, ERR: begin
            if (TRAIN_START) begin
               state_n      = LOAD;
               rev_n        = REV_EN;
               cnt_n        = '0;
               pass_n       = 1'b0;
               in_run_n     = 1'b0;
               run_start_n  = '0;
               best_start_n = '0;
               best_end_n   = '0;
               best_width_n = '0;
               tap_n        = '0;
            end
         end
         LOAD: begin
            cnt_n   = '0;
            state_n = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYC - 1)) begin
               cnt_n   = '0;
               pass_n  = 1'b1;
               state_n = SAMPLE;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         SAMPLE: begin
            if (rx_word != TRAIN_PATTERN) pass_n = 1'b0;
            if (cnt_q == CW'(SAMPLE_CNT - 1)) begin
               cnt_n   = '0;
               state_n = EVAL;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         EVAL: begin
            // A run still open at TAP_MAX is closed implicitly: best is updated every passing tap.
            if (pass_q) begin
               in_run_n    = 1'b1;
               run_start_n = run_s;
               if (width > best_width_q) begin
                  best_start_n = run_s;
                  best_end_n   = tap_q;
                  best_width_n = width;
               end
            end else begin
               in_run_n = 1'b0;
            end
            state_n = (tap_q < 7'(TAP_MAX)) ? STEP : RELOAD;
         end
         STEP: begin
            tap_n   = tap_q + 7'd1;
            state_n = SETTLE;
         end
         RELOAD: begin
            if (best_width_q < 8'(MIN_EYE)) begin
               state_n = ERR;
            end else begin
               tap_n    = '0;
               target_n = mid_sum[7:1];
               state_n  = SEEK_SETTLE;
            end
         end
         SEEK_SETTLE: state_n = (tap_q == target_q) ? DONE : SEEK_MOVE;
         SEEK_MOVE: begin
            tap_n   = tap_q + 7'd1;
            state_n = SEEK_SETTLE;
         end
         default: state_n = IDLE;
      endcase

      // Pulse outputs are registered off the next state so they align with the state they belong to.
      dly_load_n = (state_n == LOAD) ||
                   ((state_n == RELOAD) && (best_width_n >= 8'(MIN_EYE)));
      dly_move_n = (state_n == STEP) || (state_n == SEEK_MOVE);
      busy_n     = !((state_n == IDLE) || (state_n == DONE) || (state_n == ERR));
      done_n     = (state_n == DONE);
      err_n      = (state_n == ERR);
   end

   always_ff @(posedge SCLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= IDLE;
         rev_q        <= 1'b0;
         cnt_q        <= '0;
         pass_q       <= 1'b0;
         in_run_q     <= 1'b0;
         run_start_q  <= '0;
         best_start_q <= '0;
         best_end_q   <= '0;
         best_width_q <= '0;
         target_q     <= '0;
         tap_q        <= '0;
         dly_load_q   <= 1'b0;
         dly_move_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_n;
         rev_q        <= rev_n;
         cnt_q        <= cnt_n;
         pass_q       <= pass_n;
         in_run_q     <= in_run_n;
         run_start_q  <= run_start_n;
         best_start_q <= best_start_n;
         best_end_q   <= best_end_n;
         best_width_q <= best_width_n;
         target_q     <= target_n;
         tap_q        <= tap_n;
         dly_load_q   <= dly_load_n;
         dly_move_q   <= dly_move_n;
         busy_q       <= busy_n;
         done_q       <= done_n;
         err_q        <= err_n;
      end
   end

   assign DLY_LOAD   = dly_load_q;
   assign DLY_MOVE   = dly_move_q;
   assign TAP_CUR    = tap_q;
   assign EYE_START  = best_start_q;
   assign EYE_END    = best_end_q;
   assign BUSY       = busy_q;
   assign TRAIN_DONE = done_q;
   assign TRAIN_ERR  = err_q;

endmodule

// File: tb/tb_rx_bitalign_train_ctrl.sv
// Directed bench for rx_bitalign_train_ctrl: a modelled IOD tap drives the lane word,
// table-driven training scenarios plus a mid-sweep reset sequence.
module tb_rx_bitalign_train_ctrl;

   localparam int TAP_MAX  = 127;
   localparam int PER_TAP  = 8 + 16 + 2;
   localparam int SWEEP    = (TAP_MAX + 1) * PER_TAP;

   logic       SCLK = 1'b0;
   logic       RESET;
   logic       TRAIN_START;
   logic       REV_EN;
   logic [7:0] RX_DATA;
   logic       DLY_LOAD, DLY_MOVE;
   logic [6:0] TAP_CUR, EYE_START, EYE_END;
   logic       BUSY, TRAIN_DONE, TRAIN_ERR;

   rx_bitalign_train_ctrl #(
      .TAP_MAX       (TAP_MAX),
      .SETTLE_CYC    (8),
      .SAMPLE_CNT    (16),
      .TRAIN_PATTERN (8'hB4),
      .MIN_EYE       (4)
   ) dut (
      .SCLK        (SCLK),
      .RESET       (RESET),
      .TRAIN_START (TRAIN_START),
      .REV_EN      (REV_EN),
      .RX_DATA     (RX_DATA),
      .DLY_LOAD    (DLY_LOAD),
      .DLY_MOVE    (DLY_MOVE),
      .TAP_CUR     (TAP_CUR),
      .EYE_START   (EYE_START),
      .EYE_END     (EYE_END),
      .BUSY        (BUSY),
      .TRAIN_DONE  (TRAIN_DONE),
      .TRAIN_ERR   (TRAIN_ERR)
   );

   always #5 SCLK = ~SCLK;

   // IOD delay line model; not reset, so it stays stale across a controller reset.
   int iod_tap = 0;
   always @(posedge SCLK) begin
      if (DLY_LOAD)      iod_tap <= 0;
      else if (DLY_MOVE) iod_tap <= iod_tap + 1;
   end

   int         w_alo = -1, w_ahi = -1, w_blo = -1, w_bhi = -1, w_hole = -1;
   logic [7:0] w_good = 8'hB4;

   function automatic logic [7:0] lane_word(input int tap, input int alo, input int ahi,
                                            input int blo, input int bhi, input int hole,
                                            input logic [7:0] good);
      if (tap != hole && ((tap >= alo && tap <= ahi) || (tap >= blo && tap <= bhi)))
         return good;
      return 8'h00;
   endfunction

   assign RX_DATA = lane_word(iod_tap, w_alo, w_ahi, w_blo, w_bhi, w_hole, w_good);

   typedef struct {
      int         alo, ahi, blo, bhi, hole;
      logic [7:0] good;
      logic       rev;
      logic       exp_done;
      int         exp_start, exp_end, exp_tgt;
   } vec_t;

   vec_t vecs[10];

   int   n_checks = 0, n_fail = 0;
   int   ncyc = 0, load_cnt = 0, move_since_load = 0;
   int   first_load_cyc = 0, last_load_cyc = 0, end_cyc = 0;
   int   overlap_cnt = 0, b2b_cnt = 0;
   logic prev_move = 1'b0;

   function automatic vec_t mk(input int alo, input int ahi, input int blo, input int bhi,
                               input int hole, input logic [7:0] good, input logic rev,
                               input logic ed, input int es, input int ee, input int et);
      vec_t v;
      v.alo = alo; v.ahi = ahi; v.blo = blo; v.bhi = bhi; v.hole = hole;
      v.good = good; v.rev = rev; v.exp_done = ed;
      v.exp_start = es; v.exp_end = ee; v.exp_tgt = et;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge SCLK);
      #1;
      ncyc++;
      if (DLY_LOAD) begin
         load_cnt++;
         if (load_cnt == 1) first_load_cyc = ncyc;
         last_load_cyc   = ncyc;
         move_since_load = 0;
      end
      if (DLY_MOVE) move_since_load++;
      if (DLY_LOAD && DLY_MOVE) overlap_cnt++;
      if (DLY_MOVE && prev_move) b2b_cnt++;
      prev_move = DLY_MOVE;
   endtask

   task automatic set_lane(input vec_t v);
      w_alo = v.alo; w_ahi = v.ahi; w_blo = v.blo; w_bhi = v.bhi;
      w_hole = v.hole; w_good = v.good;
   endtask

   task automatic run_train(input logic rev, input bit poke, input string tag);
      bit finished;
      load_cnt = 0; move_since_load = 0; first_load_cyc = 0; last_load_cyc = 0;
      REV_EN = rev;
      TRAIN_START = 1'b1;
      step();
      TRAIN_START = 1'b0;
      REV_EN = 1'b0;
      check({tag, "_start_load"}, int'(DLY_LOAD), 1);
      check({tag, "_start_busy"}, int'(BUSY), 1);
      finished = 1'b0;
      for (int i = 0; i < SWEEP + 400 && !finished; i++) begin
         if (poke && (i % 700) == 350) TRAIN_START = 1'b1;
         step();
         TRAIN_START = 1'b0;
         if (TRAIN_DONE || TRAIN_ERR) begin
            finished = 1'b1;
            end_cyc  = ncyc;
         end
      end
      check({tag, "_finished"}, int'(finished), 1);
   endtask

   task automatic check_result(input vec_t v, input string tag);
      check({tag, "_done"},      int'(TRAIN_DONE), int'(v.exp_done));
      check({tag, "_err"},       int'(TRAIN_ERR),  int'(!v.exp_done));
      check({tag, "_busy"},      int'(BUSY),       0);
      check({tag, "_eye_start"}, int'(EYE_START),  v.exp_start);
      check({tag, "_eye_end"},   int'(EYE_END),    v.exp_end);
      if (v.exp_done) begin
         check({tag, "_loads"},      load_cnt,                       2);
         check({tag, "_sweep_cyc"},  last_load_cyc - first_load_cyc, SWEEP);
         check({tag, "_tap_cur"},    int'(TAP_CUR),                  v.exp_tgt);
         check({tag, "_seek_moves"}, move_since_load,                v.exp_tgt);
         check({tag, "_seek_cyc"},   end_cyc - last_load_cyc,        2 * v.exp_tgt + 2);
      end else begin
         check({tag, "_loads"},     load_cnt,                 1);
         check({tag, "_err_cyc"},   end_cyc - first_load_cyc, SWEEP + 1);
         check({tag, "_moves"},     move_since_load,          TAP_MAX);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_load"},  int'(DLY_LOAD),   0);
      check({tag, "_move"},  int'(DLY_MOVE),   0);
      check({tag, "_tap"},   int'(TAP_CUR),    0);
      check({tag, "_es"},    int'(EYE_START),  0);
      check({tag, "_ee"},    int'(EYE_END),    0);
      check({tag, "_busy"},  int'(BUSY),       0);
      check({tag, "_done"},  int'(TRAIN_DONE), 0);
      check({tag, "_err"},   int'(TRAIN_ERR),  0);
   endtask

   initial begin
      bit reached;
      //              alo  ahi  blo  bhi  hole good   rev  done  es   ee  tgt
      vecs[0] = mk(  20,  50,  -1,  -1,  -1, 8'hB4, 1'b0, 1'b1,  20,  50, 35);
      vecs[1] = mk(   0,   9,  -1,  -1,  -1, 8'h2D, 1'b1, 1'b1,   0,   9,  4);
      vecs[2] = mk(   0,   9,  -1,  -1,  -1, 8'hB4, 1'b1, 1'b0,   0,   0,  0);
      vecs[3] = mk(  10,  14,  60,  90,  -1, 8'hB4, 1'b0, 1'b1,  60,  90, 75);
      vecs[4] = mk(  10,  20,  40,  50,  -1, 8'hB4, 1'b0, 1'b1,  10,  20, 15);
      vecs[5] = mk( 120, 127,  -1,  -1,  -1, 8'hB4, 1'b0, 1'b1, 120, 127, 123);
      vecs[6] = mk( 120, 127,  -1,  -1, 125, 8'hB4, 1'b0, 1'b1, 120, 124, 122);
      vecs[7] = mk(  -1,  -1,  -1,  -1,  -1, 8'hB4, 1'b0, 1'b0,   0,   0,  0);
      vecs[8] = mk(  30,  32,  -1,  -1,  -1, 8'hB4, 1'b0, 1'b0,  30,  32,  0);
      vecs[9] = mk(  30,  33,  -1,  -1,  -1, 8'hB4, 1'b0, 1'b1,  30,  33, 31);

      RESET = 1'b1; TRAIN_START = 1'b0; REV_EN = 1'b0;
      step(); step();
      check_all_zero("reset");
      RESET = 1'b0;
      step();

      for (int i = 0; i < 10; i++) begin
         set_lane(vecs[i]);
         run_train(vecs[i].rev, 1'b0, $sformatf("vec%0d", i));
         check_result(vecs[i], $sformatf("vec%0d", i));
         step();
      end

      // Asynchronous reset mid-SAMPLE at tap 40, then a clean restart with start pokes while busy.
      set_lane(vecs[0]);
      TRAIN_START = 1'b1;
      step();
      TRAIN_START = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < SWEEP && !reached; i++) begin
         step();
         if (TAP_CUR == 7'd40) reached = 1'b1;
      end
      check("rst_reach_tap40", int'(reached), 1);
      repeat (10) step();
      check("rst_pre_eye_start", int'(EYE_START), 20);
      #2 RESET = 1'b1;
      #1;
      check_all_zero("rst_async");
      step(); step();
      RESET = 1'b0;
      load_cnt = 0; move_since_load = 0;
      repeat (6) step();
      check("rst_after_loads", load_cnt, 0);
      check("rst_after_moves", move_since_load, 0);
      check_all_zero("rst_idle");
      run_train(1'b0, 1'b1, "rerun");
      check_result(vecs[0], "rerun");

      check("pulse_overlap", overlap_cnt, 0);
      check("move_back_to_back", b2b_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
